// File: rtl/aes_pkg.sv
// AES types, sizes and the FIPS-197 forward S-box table, shared by the
// encryption-side datapath blocks.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AES_BYTE_W-1:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox_fwd.sv
// Forward AES S-box, one byte.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup with no state.
module aes_sbox_fwd
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] din_i,
    output logic [AES_BYTE_W-1:0] dout_o
);

    assign dout_o = SBOX_FWD[din_i];

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative forward SubBytes: BYTES_PER_CYCLE bytes per clock through shared S-boxes.
// Latency: result valid NUM_STEPS cycles after the accept edge; one result per NUM_STEPS+1 cycles.
// Backpressure: valid/ready both sides; result holds while out_ready is low, in_ready follows out_ready in DONE.
module aes_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   busy
);

    localparam int NUM_STEPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("aes_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [AES_BLOCK_W-1:0]  work_q;
    logic [AES_BLOCK_W-1:0]  work_d;
    logic                    out_valid_q;
    logic                    busy_q;

    logic [AES_BYTE_W-1:0]   sb_in  [BYTES_PER_CYCLE];
    logic [AES_BYTE_W-1:0]   sb_out [BYTES_PER_CYCLE];

    // Group selected by the step counter, ascending byte index.
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sb_in[j] = work_q[(int'(cnt_q) * BYTES_PER_CYCLE + j) * AES_BYTE_W +: AES_BYTE_W];
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        aes_sbox_fwd u_sbox (
            .din_i  (sb_in[g]),
            .dout_o (sb_out[g])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            work_d[(int'(cnt_q) * BYTES_PER_CYCLE + j) * AES_BYTE_W +: AES_BYTE_W] = sb_out[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_block;
                        cnt_q   <= '0;
                        state_q <= SUB;
                        busy_q  <= 1'b1;
                    end
                end
                SUB: begin
                    work_q <= work_d;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        // Retire and reload in the same cycle keeps back-to-back blocks bubble-free.
                        if (in_valid) begin
                            work_q  <= in_block;
                            cnt_q   <= '0;
                            state_q <= SUB;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign out_block = work_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Bench for aes_sub_bytes_iter: directed and random blocks against a GF(2^8)
// inverse + affine S-box reference; extra instances cover the other BYTES_PER_CYCLE values.
module tb_aes_sub_bytes_iter;

    localparam int NSTEPS = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    logic         x_in_valid  [4];
    logic         x_in_ready  [4];
    logic [127:0] x_in_block;
    logic         x_out_valid [4];
    logic         x_out_ready [4];
    logic [127:0] x_out_block [4];
    logic         x_busy      [4];

    int checks;
    int errors;

    logic [7:0] ref_sb [256];

    aes_sub_bytes_iter #(.BYTES_PER_CYCLE(NSTEPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_xdut
        localparam int XB = (g < 2) ? (1 << g) : (1 << (g + 1));
        aes_sub_bytes_iter #(.BYTES_PER_CYCLE(XB)) u_x (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (x_in_valid[g]),
            .in_ready  (x_in_ready[g]),
            .in_block  (x_in_block),
            .out_valid (x_out_valid[g]),
            .out_ready (x_out_ready[g]),
            .out_block (x_out_block[g]),
            .busy      (x_busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = (v << n) | (v >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] blk_ref(input logic [127:0] b);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = ref_sb[b[i*8 +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input logic [127:0] blk, input int stall, input string tag,
                             output logic [127:0] got);
        logic [127:0] exp;
        int lat;
        exp = blk_ref(blk);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_block  = blk;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_block = {4{$urandom}};
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(NSTEPS));
        got = out_block;
        check({tag, "_data"}, out_block, exp);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {out_valid, out_block}, {1'b1, exp});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_retire"}, 128'(out_valid), 128'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] blk;
        logic [127:0] exp;
        logic [127:0] x_got [4];
        int           x_lat [4];
        int           beats;

        checks     = 0;
        errors     = 0;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_block   = '0;
        out_ready  = 1'b0;
        x_in_block = '0;
        for (int g = 0; g < 4; g++) begin
            x_in_valid[g]  = 1'b0;
            x_out_ready[g] = 1'b0;
        end
        for (int x = 0; x < 256; x++) ref_sb[x] = sbox_ref(8'(x));

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", {out_valid, busy, in_ready, out_block}, {1'b0, 1'b0, 1'b1, 128'h0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: all-zero block, cycle-accurate latency
        in_block  = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t1_in_ready_drop", 128'(in_ready), 128'(0));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("t1_out_valid", 128'(out_valid), 128'(k == 4));
            check("t1_busy", 128'(busy), 128'(1));
        end
        check("t1_data", out_block, {16{8'h63}});
        @(posedge clk); #1;
        check("t1_idle", {out_valid, busy, in_ready}, 128'(3'b001));
        out_ready = 1'b0;

        // 2: FIPS-197 App. B round-1 state
        run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 0, "t2_fips", got);
        check("t2_fips_const", got, 128'hd42711aee0bf98f1b8b45de51e415230);

        x_in_block = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        for (int g = 0; g < 4; g++) begin
            check("t2_x_in_ready", 128'(x_in_ready[g]), 128'(1));
            x_in_valid[g]  = 1'b1;
            x_out_ready[g] = 1'b1;
            x_lat[g]       = 0;
            x_got[g]       = '0;
        end
        @(posedge clk); #1;
        for (int g = 0; g < 4; g++) begin
            x_in_valid[g] = 1'b0;
            check("t2_x_busy", 128'(x_busy[g]), 128'(1));
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 4; g++) begin
                if (x_out_valid[g] === 1'b1 && x_lat[g] == 0) begin
                    x_lat[g] = cyc;
                    x_got[g] = x_out_block[g];
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            check("t2_x_latency", 128'(x_lat[g]), 128'(16 / ((g < 2) ? (1 << g) : (1 << (g + 1)))));
            check("t2_x_data", x_got[g], 128'hd42711aee0bf98f1b8b45de51e415230);
        end

        // 3: downstream stall in DONE, new input must be ignored
        blk = {4{$urandom}};
        exp = blk_ref(blk);
        in_block  = blk;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        beats = 0;
        while (out_valid !== 1'b1 && beats < 40) begin
            @(posedge clk); #1;
            beats++;
        end
        check("t3_latency", 128'(beats), 128'(NSTEPS));
        in_valid = 1'b1;
        in_block = ~blk;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("t3_hold", {out_valid, in_ready, busy, out_block}, {1'b1, 1'b0, 1'b1, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_release", {out_valid, busy, in_ready}, 128'(3'b001));
        beats = 0;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            beats += int'(out_valid);
        end
        check("t3_no_extra_beat", 128'(beats), 128'(0));

        // 4: back-to-back with in_valid held
        in_block  = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_block = {16{8'hff}};
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            check("t4_out_valid", 128'(out_valid), 128'(k == 4 || k == 9));
            check("t4_busy", 128'(busy), 128'(k <= 9));
            if (k == 4) begin
                check("t4_first", out_block, {16{8'h63}});
                check("t4_pass_ready", 128'(in_ready), 128'(1));
            end
            if (k == 9) check("t4_second", out_block, {16{8'h16}});
            if (k == 5) in_valid = 1'b0;
        end
        out_ready = 1'b0;

        // 5: reset mid-SUB at cnt==2
        in_block  = {4{$urandom}};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_reset_async", {out_valid, busy, in_ready, out_block}, {1'b0, 1'b0, 1'b1, 128'h0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        beats = 0;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            beats += int'(out_valid);
        end
        check("t5_no_beat", 128'(beats), 128'(0));
        check("t5_idle", {busy, in_ready, out_block}, {1'b0, 1'b1, 128'h0});
        out_ready = 1'b0;
        run_block({4{$urandom}}, 1, "t5_after", got);

        // 6: every byte value, spread over all positions
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) blk[i*8 +: 8] = {4'((b + i) % 16), 4'(i)};
            run_block(blk, 0, "t6_exhaustive", got);
        end
        blk = {{13{8'h00}}, 8'hff, 8'h01, 8'h53};
        run_block(blk, 0, "t6_known", got);
        check("t6_known_bytes", 128'(got[23:0]), 128'(24'h167ced));

        // Random blocks with random stalls
        for (int r = 0; r < 12; r++) begin
            run_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), "rand", got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
